// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream
// (length, data words, checksum) into word writes and holds the core until verified.
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_BYTES = 4,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [7:0]              byte_i,
    input  logic                    byte_valid_i,
    output logic                    byte_ready_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [ADDR_WIDTH-1:0]   waddr_o,
    output logic [DATA_BYTES-1:0]   wen_o,
    output logic                    core_hold_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [ADDR_WIDTH:0]     word_cnt_o
);

    localparam int CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(DATA_BYTES - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_WORDS = DATA_WIDTH'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);

    // CHECK is the one-cycle registered compare between the last checksum byte and DONE/ERROR
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       byte_cnt_reg;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [DATA_WIDTH-1:0]  csum_reg;
    logic [ADDR_WIDTH:0]    len_reg;
    logic                   csum_ok_reg;

    logic                   accept;
    logic                   last_byte;
    logic [DATA_WIDTH-1:0]  word_full;

    assign accept    = byte_valid_i && byte_ready_o;
    assign last_byte = accept && (byte_cnt_reg == LAST_BYTE);
    // Bytes shift in from the top, so the first byte of a field ends up in [7:0]
    assign word_full = {byte_i, shift_reg[DATA_WIDTH-1:8]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
            csum_reg     <= '0;
            len_reg      <= '0;
            csum_ok_reg  <= 1'b0;
            byte_ready_o <= 1'b0;
            wdata_o      <= '0;
            waddr_o      <= '0;
            wen_o        <= '0;
            core_hold_o  <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            word_cnt_o   <= '0;
        end else begin
            // The write pulse lasts one cycle; address and count advance as it ends
            if (wen_o != '0) begin
                wen_o      <= '0;
                waddr_o    <= waddr_o + 1'b1;
                word_cnt_o <= word_cnt_o + CNT_ONE;
            end

            if (accept) begin
                shift_reg    <= word_full;
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end

            case (state_reg)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_i) begin
                        state_reg    <= S_LEN;
                        byte_ready_o <= 1'b1;
                        core_hold_o  <= 1'b1;
                        done_o       <= 1'b0;
                        err_o        <= 1'b0;
                        byte_cnt_reg <= '0;
                        word_cnt_o   <= '0;
                        waddr_o      <= '0;
                        csum_reg     <= '0;
                    end
                end
                S_LEN: begin
                    if (last_byte) begin
                        len_reg <= word_full[ADDR_WIDTH:0];
                        if (word_full == '0) begin
                            state_reg <= S_CSUM;
                        end else if (word_full > MAX_WORDS) begin
                            state_reg    <= S_ERROR;
                            byte_ready_o <= 1'b0;
                            err_o        <= 1'b1;
                        end else begin
                            state_reg <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (last_byte) begin
                        wdata_o  <= word_full;
                        wen_o    <= '1;
                        csum_reg <= csum_reg + word_full;
                        if (word_cnt_o + CNT_ONE == len_reg) begin
                            state_reg <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (last_byte) begin
                        csum_ok_reg  <= (word_full == csum_reg);
                        state_reg    <= S_CHECK;
                        byte_ready_o <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (csum_ok_reg) begin
                        state_reg   <= S_DONE;
                        done_o      <= 1'b1;
                        core_hold_o <= 1'b0;
                    end else begin
                        state_reg <= S_ERROR;
                        err_o     <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= S_IDLE;
                    byte_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a stream model queues expected
// writes and final status; a negedge monitor checks every write pulse.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic [31:0] wdata_o;
    logic [9:0]  waddr_o;
    logic [3:0]  wen_o;
    logic        core_hold_o;
    logic        done_o;
    logic        err_o;
    logic [10:0] word_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [41:0] exp_q[$];
    logic [31:0] words_q[$];
    bit          prev_wen = 1'b0;

    imem_loader #(
        .DATA_WIDTH(32),
        .DATA_BYTES(4),
        .ADDR_WIDTH(10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .wdata_o      (wdata_o),
        .waddr_o      (waddr_o),
        .wen_o        (wen_o),
        .core_hold_o  (core_hold_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .word_cnt_o   (word_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, required simulation end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the next expected (addr, data) and last one cycle
    always @(negedge clk) begin
        if (!rst && wen_o != 4'h0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%h, required no write", waddr_o, wdata_o);
            end else begin
                logic [41:0] e;
                e = exp_q.pop_front();
                if (wen_o !== 4'hF || waddr_o !== e[41:32] || wdata_o !== e[31:0] || prev_wen) begin
                    errors++;
                    $display("FAIL write: got wen=%h addr=%0h data=%h back2back=%0d, required wen=f addr=%0h data=%h back2back=0",
                             wen_o, waddr_o, wdata_o, prev_wen, e[41:32], e[31:0]);
                end else begin
                    $display("write addr=%0h data=%h ok", waddr_o, wdata_o);
                end
            end
        end
        prev_wen = !rst && (wen_o != 4'h0);
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_byte_ready"}, byte_ready_o, 0);
        chk({tag, "_wdata"},      wdata_o, 0);
        chk({tag, "_waddr"},      waddr_o, 0);
        chk({tag, "_wen"},        wen_o, 0);
        chk({tag, "_core_hold"},  core_hold_o, 1);
        chk({tag, "_done"},       done_o, 0);
        chk({tag, "_err"},        err_o, 0);
        chk({tag, "_word_cnt"},   word_cnt_o, 0);
    endtask

    task automatic start_load();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("ready_in_len", byte_ready_o, 1);
    endtask

    // Present one byte; transfers on the posedge following a negedge where ready was seen
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  waitc = 0;
        bit  sent  = 1'b0;
        while (!sent) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 1) == 0) begin
                byte_valid_i = 1'b0;
            end else if (!byte_ready_o) begin
                byte_valid_i = 1'b0;
                waitc++;
                if (waitc > 50) begin
                    chk("ready_timeout", byte_ready_o, 1);
                    sent = 1'b1;
                end
            end else begin
                byte_i       = b;
                byte_valid_i = 1'b1;
                sent         = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model: build the stream and expected writes from words_q, then drive it.
    // cut >= 0 stops after that many bytes (the caller then applies reset).
    task automatic run_load(input int n, input bit bad, input bit gaps, input bit redund, input int cut);
        logic [31:0] sum = 32'h0;
        logic [31:0] lenw;
        logic [31:0] csw;
        logic [7:0]  bq[$];
        lenw = 32'(n);
        for (int b = 0; b < 4; b++) bq.push_back(lenw[8*b +: 8]);
        if (n <= 1024) begin
            for (int i = 0; i < n; i++) begin
                logic [31:0] w;
                w = words_q[i];
                sum += w;
                for (int b = 0; b < 4; b++) bq.push_back(w[8*b +: 8]);
                if (cut < 0 || (i + 1) * 4 + 4 <= cut) exp_q.push_back({10'(i), w});
            end
            csw = bad ? sum + 32'h1 : sum;
            for (int b = 0; b < 4; b++) bq.push_back(csw[8*b +: 8]);
        end
        $display("load n=%0d bad=%0d gaps=%0d redundant_start=%0d cut=%0d csum=%h", n, bad, gaps, redund, cut, csw);
        start_load();
        for (int k = 0; k < bq.size(); k++) begin
            if (cut >= 0 && k == cut) break;
            if (redund && k == 6) start_i = 1'b1;
            send_byte(bq[k], gaps);
            start_i = 1'b0;
        end
    endtask

    // lat: cycles after the final accepted byte before done/err appear
    task automatic check_end(input string tag, input int n, input bit exp_done, input int lat);
        @(negedge clk);
        byte_valid_i = 1'b0;
        if (lat == 2) begin
            chk({tag, "_compare_latency"}, {done_o, err_o}, 0);
            @(negedge clk);
        end
        chk({tag, "_done"},       done_o, exp_done);
        chk({tag, "_err"},        err_o, !exp_done);
        chk({tag, "_core_hold"},  core_hold_o, !exp_done);
        chk({tag, "_word_cnt"},   word_cnt_o, (n > 1024) ? 0 : n);
        chk({tag, "_waddr"},      waddr_o, (n > 1024) ? 0 : (n % 1024));
        chk({tag, "_byte_ready"}, byte_ready_o, 0);
        chk({tag, "_pending_writes"}, exp_q.size(), 0);
        $display("end %s done=%0d err=%0d word_cnt=%0d", tag, done_o, err_o, word_cnt_o);
    endtask

    task automatic rand_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom());
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        byte_i       = 8'h0;
        byte_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", byte_ready_o, 0);

        words_q = '{32'h00000013, 32'h00A00093};
        run_load(2, 1'b0, 1'b0, 1'b0, -1);
        check_end("two_words", 2, 1'b1, 2);

        words_q.delete();
        run_load(0, 1'b0, 1'b0, 1'b0, -1);
        check_end("empty", 0, 1'b1, 2);

        words_q = '{32'h12345678};
        run_load(1, 1'b1, 1'b0, 1'b0, -1);
        check_end("bad_csum", 1, 1'b0, 2);

        rand_words(5);
        run_load(5, 1'b0, 1'b1, 1'b1, -1);
        check_end("gaps_redundant_start", 5, 1'b1, 2);

        words_q.delete();
        run_load(1025, 1'b0, 1'b0, 1'b0, -1);
        check_end("too_long", 1025, 1'b0, 1);

        rand_words(3);
        run_load(3, 1'b0, 1'b0, 1'b0, 6);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        exp_q.delete();
        byte_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hold_wen", wen_o, 0);
        rst = 1'b0;
        rand_words(3);
        run_load(3, 1'b0, 1'b0, 1'b0, -1);
        check_end("after_reset", 3, 1'b1, 2);

        rand_words(1024);
        run_load(1024, 1'b0, 1'b0, 1'b0, -1);
        check_end("full_wrap", 1024, 1'b1, 2);

        for (int r = 0; r < 6; r++) begin
            int n;
            bit bad;
            n   = $urandom_range(1, 8);
            bad = ($urandom_range(0, 3) == 0);
            rand_words(n);
            run_load(n, bad, bit'($urandom_range(0, 1)), 1'b0, -1);
            check_end("random", n, !bad, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
